// File: rtl/histogram_pkg.sv
// Shared types for the histogram engine: FSM state encoding and the
// accumulate-pipeline stage record.
package histogram_pkg;

    // Widest bin index the engine supports (4096 bins).
    localparam int unsigned MaxDataW = 12;

    typedef enum logic [1:0] {
        StClear,
        StAccum,
        StDrain,
        StDump
    } state_e;

    // One accumulate pipeline stage. fwd means the RAM read for this sample
    // coincided with a write to the same bin, so the read data is stale and
    // the last written value must be used instead.
    typedef struct packed {
        logic                valid;
        logic [MaxDataW-1:0] bin;
        logic                fwd;
    } stage_t;

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// 1-cycle registered read. A read and write to the same address on the same
// edge returns the old contents. Read data holds while re_i is low.
module hist_ram #(
    parameter int unsigned Depth = 128,
    parameter int unsigned Width = 10,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Write port and read-first registered read port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/histogram_engine.sv
// Histogram engine: clears all bins, accumulates per-bin hit counts from a
// sample stream, then dumps and clears every bin on request.
// Optional feature: define HIST_SATURATE_EN to make counters saturate at
// their maximum instead of wrapping to zero.
module histogram_engine
    import histogram_pkg::*;
#(
    parameter int unsigned BINS  = 128,
    parameter int unsigned CNT_W = 10,
    localparam int unsigned DATA_W = $clog2(BINS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              rd_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_bin,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              busy
);

    localparam logic [DATA_W:0]   BinsExt = (DATA_W + 1)'(BINS);
    localparam logic [DATA_W-1:0] LastBin = DATA_W'(BINS - 1);

    state_e              state_q;
    logic [DATA_W-1:0]   clr_idx_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                drain_cnt_q;
    stage_t              s1_q;
    logic [CNT_W-1:0]    last_wdata_q;
    logic [DATA_W-1:0]   rd_idx_q;
    logic [DATA_W-1:0]   rd_bin_q;
    logic                rd_pend_q;
    logic                rd_done_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_bin_q;
    logic [CNT_W-1:0]    out_count_q;
    logic                out_last_q;

    logic                accept;
    logic                hit;
    logic [DATA_W-1:0]   s1_bin;
    logic [CNT_W-1:0]    base;
    logic [CNT_W-1:0]    cnt_d;
    logic                out_hs;
    logic                load;
    logic                issue;

    logic                ram_we;
    logic [DATA_W-1:0]   ram_waddr;
    logic [CNT_W-1:0]    ram_wdata;
    logic                ram_re;
    logic [DATA_W-1:0]   ram_raddr;
    logic [CNT_W-1:0]    ram_rdata;

    logic                unused_s1_bin;
    assign unused_s1_bin = ^s1_q.bin;

    hist_ram #(
        .Depth (BINS),
        .Width (CNT_W)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Accumulate datapath and dump handshake decode.
    always_comb begin
        accept = in_valid && in_ready_q;
        hit    = accept && ({1'b0, in_data} < BinsExt);
        s1_bin = s1_q.bin[DATA_W-1:0];
        // Only a same-bin hit one cycle earlier needs forwarding: the RAM is
        // read-first, while a hit two cycles earlier is already in the array.
        base   = s1_q.fwd ? last_wdata_q : ram_rdata;
`ifdef HIST_SATURATE_EN
        cnt_d  = (&base) ? base : base + 1'b1;
`else
        cnt_d  = base + 1'b1;
`endif
        out_hs = out_valid_q && out_ready;
        // Pending read word moves into the output register when it is free.
        load   = rd_pend_q && (!out_valid_q || out_ready);
        issue  = (state_q == StDump) && !rd_done_q && (!rd_pend_q || load);
    end

    // RAM port steering per FSM state.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_idx_q;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = in_data;
        unique case (state_q)
            StClear: begin
                ram_we = 1'b1;
            end
            StAccum, StDrain: begin
                ram_we    = s1_q.valid;
                ram_waddr = s1_bin;
                ram_wdata = cnt_d;
                ram_re    = hit;
            end
            StDump: begin
                ram_we    = out_hs;
                ram_waddr = out_bin_q;
                ram_re    = issue;
                ram_raddr = rd_idx_q;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Control FSM, accumulate pipeline and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StClear;
            clr_idx_q    <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            drain_cnt_q  <= 1'b0;
            s1_q         <= '0;
            last_wdata_q <= '0;
            rd_idx_q     <= '0;
            rd_bin_q     <= '0;
            rd_pend_q    <= 1'b0;
            rd_done_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bin_q    <= '0;
            out_count_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            s1_q.valid <= hit;
            s1_q.bin   <= MaxDataW'(in_data);
            s1_q.fwd   <= hit && s1_q.valid && (s1_bin == in_data);
            if (s1_q.valid) begin
                last_wdata_q <= cnt_d;
            end

            unique case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LastBin) begin
                        state_q    <= StAccum;
                        clr_idx_q  <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                StAccum: begin
                    if (rd_start) begin
                        state_q     <= StDrain;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        drain_cnt_q <= 1'b0;
                    end
                end
                StDrain: begin
                    drain_cnt_q <= 1'b1;
                    if (drain_cnt_q) begin
                        state_q   <= StDump;
                        rd_idx_q  <= '0;
                        rd_pend_q <= 1'b0;
                        rd_done_q <= 1'b0;
                    end
                end
                StDump: begin
                    if (issue) begin
                        rd_pend_q <= 1'b1;
                        rd_bin_q  <= rd_idx_q;
                        rd_idx_q  <= rd_idx_q + 1'b1;
                        if (rd_idx_q == LastBin) begin
                            rd_done_q <= 1'b1;
                        end
                    end else if (load) begin
                        rd_pend_q <= 1'b0;
                    end

                    if (load) begin
                        out_valid_q <= 1'b1;
                        out_bin_q   <= rd_bin_q;
                        out_count_q <= ram_rdata;
                        out_last_q  <= (rd_bin_q == LastBin);
                    end else if (out_hs) begin
                        out_valid_q <= 1'b0;
                    end

                    if (out_hs && out_last_q) begin
                        state_q    <= StAccum;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        out_last_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StClear;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: two instances (128 bins x 10 bits, 100 bins x
// 2 bits) share one stimulus stream and are checked against per-bin counts.
module tb_histogram_engine;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] in_data = '0;
    logic       rd_start = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [6:0] out_bin_a;
    logic [9:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [6:0] out_bin_b;
    logic [1:0] out_count_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned cnt_a [128];
    int unsigned cnt_b [100];

    always #5 CLK = ~CLK;

    histogram_engine #(.BINS(128), .CNT_W(10)) u_dut_a (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .rd_start(rd_start), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_bin(out_bin_a), .out_count(out_count_a), .out_last(out_last_a), .busy(busy_a)
    );

    histogram_engine #(.BINS(100), .CNT_W(2)) u_dut_b (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .rd_start(rd_start), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_bin(out_bin_b), .out_count(out_count_b), .out_last(out_last_b), .busy(busy_b)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Next count after one hit for a counter whose maximum is mx.
    function automatic int unsigned bump(input int unsigned c, input int unsigned mx);
`ifdef HIST_SATURATE_EN
        return (c == mx) ? c : c + 1;
`else
        return (c == mx) ? 0 : c + 1;
`endif
    endfunction

    task automatic model_hit(input int d);
        if (d < 128) cnt_a[d] = bump(cnt_a[d], 1023);
        if (d < 100) cnt_b[d] = bump(cnt_b[d], 3);
    endtask

    task automatic model_zero();
        foreach (cnt_a[i]) cnt_a[i] = 0;
        foreach (cnt_b[i]) cnt_b[i] = 0;
    endtask

    // Called at the negedge after a reset edge; releases reset, times the clear.
    task automatic wait_clear();
        int na;
        int nb;
        na = 0;
        nb = 0;
        RST = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (!busy_a && !busy_b) break;
            @(negedge CLK);
        end
        check("clear_cycles_a", na, 128);
        check("clear_cycles_b", nb, 100);
        check("ready_after_clear_a", in_ready_a, 1);
        check("ready_after_clear_b", in_ready_b, 1);
        model_zero();
    endtask

    task automatic feed(input int d, input int gap);
        check("feed_ready", in_ready_a & in_ready_b, 1);
        in_valid = 1'b1;
        in_data  = 7'(d);
        model_hit(d);
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic run_dump(input int stall_pct, input int with_sample, input int abort_at);
        int          lat;
        int          idx_a;
        int          idx_b;
        bit          done_a, done_b, end_a, end_b, hold_a, hold_b;
        int unsigned hb_a, hc_a, hl_a, hb_b, hc_b, hl_b;
        idx_a = 0; idx_b = 0;
        done_a = 0; done_b = 0; end_a = 0; end_b = 0; hold_a = 0; hold_b = 0;
        hb_a = 0; hc_a = 0; hl_a = 0; hb_b = 0; hc_b = 0; hl_b = 0;
        check("dump_ready_a", in_ready_a, 1);
        check("dump_ready_b", in_ready_b, 1);
        rd_start = 1'b1;
        if (with_sample >= 0) begin
            in_valid = 1'b1;
            in_data  = 7'(with_sample);
            model_hit(with_sample);
        end
        @(negedge CLK);
        rd_start = 1'b0;
        // Offered during DRAIN; must not be accepted.
        in_valid = 1'b1;
        in_data  = 7'($urandom_range(0, 127));
        check("ready_low_a", in_ready_a, 0);
        check("ready_low_b", in_ready_b, 0);
        lat = 0;
        while (!out_valid_a && lat < 12) begin
            @(negedge CLK);
            in_valid = 1'b0;
            lat++;
        end
        check("rd_latency_a", lat, 4);
        check("first_valid_b", out_valid_b, 1);

        for (int cyc = 0; cyc < 4000 && !(end_a && end_b); cyc++) begin
            if (abort_at >= 0 && out_valid_a && out_bin_a == 7'(abort_at)) begin
                RST = 1'b1;
                out_ready = 1'b0;
                @(negedge CLK);
                check("abort_valid_a", out_valid_a, 0);
                check("abort_valid_b", out_valid_b, 0);
                check("abort_busy_a", busy_a, 1);
                check("abort_last_a", out_last_a, 0);
                check("abort_ready_a", in_ready_a, 0);
                return;
            end
            if (done_a && !end_a) begin
                check("end_valid_a", out_valid_a, 0);
                check("end_ready_a", in_ready_a, 1);
                check("end_busy_a", busy_a, 0);
                end_a = 1;
            end
            if (done_b && !end_b) begin
                check("end_valid_b", out_valid_b, 0);
                check("end_ready_b", in_ready_b, 1);
                end_b = 1;
            end
            if (hold_a) begin
                check("stall_valid_a", out_valid_a, 1);
                check("stall_bin_a", out_bin_a, hb_a);
                check("stall_count_a", out_count_a, hc_a);
                check("stall_last_a", out_last_a, hl_a);
            end
            if (hold_b) begin
                check("stall_valid_b", out_valid_b, 1);
                check("stall_bin_b", out_bin_b, hb_b);
                check("stall_count_b", out_count_b, hc_b);
                check("stall_last_b", out_last_b, hl_b);
            end
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            hold_a = 0;
            if (!done_a && out_valid_a) begin
                if (out_ready) begin
                    check($sformatf("bin_a[%0d]", idx_a), out_bin_a, idx_a);
                    check($sformatf("count_a[%0d]", idx_a), out_count_a, cnt_a[idx_a]);
                    check($sformatf("last_a[%0d]", idx_a), out_last_a, (idx_a == 127) ? 1 : 0);
                    cnt_a[idx_a] = 0;
                    if (idx_a == 127) done_a = 1;
                    idx_a++;
                end else begin
                    hold_a = 1;
                    hb_a = out_bin_a; hc_a = out_count_a; hl_a = out_last_a;
                end
            end
            hold_b = 0;
            if (!done_b && out_valid_b) begin
                if (out_ready) begin
                    check($sformatf("bin_b[%0d]", idx_b), out_bin_b, idx_b);
                    check($sformatf("count_b[%0d]", idx_b), out_count_b, cnt_b[idx_b]);
                    check($sformatf("last_b[%0d]", idx_b), out_last_b, (idx_b == 99) ? 1 : 0);
                    cnt_b[idx_b] = 0;
                    if (idx_b == 99) done_b = 1;
                    idx_b++;
                end else begin
                    hold_b = 1;
                    hb_b = out_bin_b; hc_b = out_count_b; hl_b = out_last_b;
                end
            end
            @(negedge CLK);
        end
        out_ready = 1'b0;
        check("words_a", idx_a, 128);
        check("words_b", idx_b, 100);
    endtask

    initial begin
        int d;
        model_zero();
        @(negedge CLK);
        @(negedge CLK);
        check("rst_ready_a", in_ready_a, 0);
        check("rst_valid_a", out_valid_a, 0);
        check("rst_last_a", out_last_a, 0);
        check("rst_bin_a", out_bin_a, 0);
        check("rst_count_a", out_count_a, 0);
        check("rst_busy_a", busy_a, 1);
        check("rst_valid_b", out_valid_b, 0);
        check("rst_busy_b", busy_b, 1);
        wait_clear();

        // Empty histogram dump.
        run_dump(0, -1, -1);

        // Back-to-back and distance-2 hits on the same bins.
        for (int i = 0; i < 4; i++) feed(5, 0);
        feed(7, 0);
        feed(5, 0);
        feed(7, 1);
        run_dump(0, -1, -1);

        // Out-of-range for the 100-bin instance, and 2-bit overflow on bin 3.
        feed(99, 0);
        feed(100, 0);
        feed(127, 1);
        for (int i = 0; i < 5; i++) feed(3, 0);
        run_dump(0, -1, -1);

        // Random samples clustered to exercise forwarding, then stalled dumps.
        for (int i = 0; i < 300; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 60 + $urandom_range(0, 3) : $urandom_range(0, 127);
            feed(d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end
        run_dump(40, $urandom_range(0, 127), -1);
        run_dump(40, -1, -1);

        // Reset in the middle of a dump.
        for (int i = 0; i < 50; i++) feed($urandom_range(0, 127), 0);
        run_dump(30, -1, 40);
        wait_clear();
        run_dump(20, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
